move_commit_unit: RTL and testbench

- Downstream of the AI search engine: consumes its chosen move (piece_to_move, output_move, done) and commits it to the board state.
- Owns the authoritative per-side location and alive vectors that the engine and move generator read.
- Scans all 16 opposing and 16 own pieces sequentially to detect captures and illegal destinations, then updates the state atomically.

---
 rtl/move_commit_unit.sv | 251 +++++++++++++++++++++++++
 tb/tb_move_commit_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/move_commit_unit.sv
// Commits the search engine's chosen move to the authoritative board state.
// Optional pawn promotion tracking is built when MOVE_COMMIT_PROMOTION_EN is defined.
module move_commit_unit #(
  parameter int NUM_PIECES = 16,
  parameter int SQ_W       = 6
) (
  input  logic                         clk,
  input  logic                         RST,
  input  logic                         start,
  input  logic                         pl,
  input  logic [$clog2(NUM_PIECES)-1:0] piece_id,
  input  logic [SQ_W-1:0]              dest_sq,
  output logic [NUM_PIECES*SQ_W-1:0]   location_vectors_w,
  output logic [NUM_PIECES*SQ_W-1:0]   location_vectors_b,
  output logic [NUM_PIECES-1:0]        alive_vectors_w,
  output logic [NUM_PIECES-1:0]        alive_vectors_b,
  output logic                         busy,
  output logic                         done,
  output logic [1:0]                   err,
  output logic                         captured,
  output logic [$clog2(NUM_PIECES)-1:0] captured_id,
  output logic [NUM_PIECES-1:0]        promoted_w,
  output logic [NUM_PIECES-1:0]        promoted_b
);

  localparam int IDX_W = $clog2(NUM_PIECES);
  localparam int VEC_W = NUM_PIECES * SQ_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_COMMIT = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Back-rank ids 0..7 map to files {K,Q,R1,R2,B1,N1,N2,B2}; pawn id k sits on file 15-k.
  function automatic logic [SQ_W-1:0] home_sq(input int unsigned id, input logic white);
    logic [2:0] file;
    logic [2:0] rank;
    if (id < 8) begin
      case (id)
        0:       file = 3'd4;
        1:       file = 3'd3;
        2:       file = 3'd0;
        3:       file = 3'd7;
        4:       file = 3'd2;
        5:       file = 3'd1;
        6:       file = 3'd6;
        default: file = 3'd5;
      endcase
      rank = white ? 3'd0 : 3'd7;
    end else begin
      file = 3'(15 - id);
      rank = white ? 3'd1 : 3'd6;
    end
    return {rank, file};
  endfunction

  function automatic logic [VEC_W-1:0] home_vec(input logic white);
    logic [VEC_W-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_PIECES; k++) v[k*SQ_W +: SQ_W] = home_sq(k, white);
    return v;
  endfunction

  function automatic logic [1:0] err_rank(input logic [1:0] e);
    case (e)
      2'b01:   return 2'd3;
      2'b11:   return 2'd2;
      2'b10:   return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  localparam logic [VEC_W-1:0] HOME_W = home_vec(1'b1);
  localparam logic [VEC_W-1:0] HOME_B = home_vec(1'b0);

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    pl_q, pl_d;
  logic [IDX_W-1:0]        pid_q, pid_d;
  logic [SQ_W-1:0]         dest_q, dest_d;
  logic [1:0]              err_q, err_d;
  logic                    cap_vld_q, cap_vld_d;
  logic [IDX_W-1:0]        cap_id_q, cap_id_d;
  logic [VEC_W-1:0]        loc_w_q, loc_w_d, loc_b_q, loc_b_d;
  logic [NUM_PIECES-1:0]   alive_w_q, alive_w_d, alive_b_q, alive_b_d;
  logic                    busy_q, busy_d, done_q, done_d;
  logic                    captured_q, captured_d;
  logic [IDX_W-1:0]        captured_id_q, captured_id_d;

  logic [VEC_W-1:0]        own_loc, opp_loc;
  logic [NUM_PIECES-1:0]   own_alive, opp_alive;
  logic [SQ_W-1:0]         mover_sq, own_i_sq, opp_i_sq;
  logic [1:0]              new_err;
  logic                    commit_ok;

  assign own_loc   = pl_q ? loc_w_q : loc_b_q;
  assign opp_loc   = pl_q ? loc_b_q : loc_w_q;
  assign own_alive = pl_q ? alive_w_q : alive_b_q;
  assign opp_alive = pl_q ? alive_b_q : alive_w_q;
  assign mover_sq  = own_loc[pid_q*SQ_W +: SQ_W];
  assign own_i_sq  = own_loc[idx_q*SQ_W +: SQ_W];
  assign opp_i_sq  = opp_loc[idx_q*SQ_W +: SQ_W];
  assign commit_ok = (state_q == ST_COMMIT) && (err_q == 2'b00);

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    pl_d          = pl_q;
    pid_d         = pid_q;
    dest_d        = dest_q;
    err_d         = err_q;
    cap_vld_d     = cap_vld_q;
    cap_id_d      = cap_id_q;
    loc_w_d       = loc_w_q;
    loc_b_d       = loc_b_q;
    alive_w_d     = alive_w_q;
    alive_b_d     = alive_b_q;
    captured_d    = captured_q;
    captured_id_d = captured_id_q;
    new_err       = 2'b00;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pl_d      = pl;
          pid_d     = piece_id;
          dest_d    = dest_sq;
          err_d     = 2'b00;
          cap_vld_d = 1'b0;
          cap_id_d  = '0;
          idx_d     = '0;
          state_d   = ST_CHECK;
        end
      end
      ST_CHECK: begin
        // Assign lowest priority first so higher-priority errors overwrite.
        if (own_alive[idx_q] && (idx_q != pid_q) && (own_i_sq == dest_q)) new_err = 2'b10;
        if (mover_sq == dest_q) new_err = 2'b11;
        if (!own_alive[pid_q]) new_err = 2'b01;
        if (err_rank(new_err) > err_rank(err_q)) err_d = new_err;
        if (opp_alive[idx_q] && (opp_i_sq == dest_q)) begin
          cap_vld_d = 1'b1;
          cap_id_d  = idx_q;
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_W'(NUM_PIECES - 1)) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        if (commit_ok) begin
          if (pl_q) begin
            loc_w_d[pid_q*SQ_W +: SQ_W] = dest_q;
            if (cap_vld_q) alive_b_d[cap_id_q] = 1'b0;
          end else begin
            loc_b_d[pid_q*SQ_W +: SQ_W] = dest_q;
            if (cap_vld_q) alive_w_d[cap_id_q] = 1'b0;
          end
        end
        captured_d    = commit_ok && cap_vld_q;
        captured_id_d = (commit_ok && cap_vld_q) ? cap_id_q : '0;
        state_d       = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      pl_q          <= 1'b0;
      pid_q         <= '0;
      dest_q        <= '0;
      err_q         <= 2'b00;
      cap_vld_q     <= 1'b0;
      cap_id_q      <= '0;
      loc_w_q       <= HOME_W;
      loc_b_q       <= HOME_B;
      alive_w_q     <= '1;
      alive_b_q     <= '1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      captured_q    <= 1'b0;
      captured_id_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      pl_q          <= pl_d;
      pid_q         <= pid_d;
      dest_q        <= dest_d;
      err_q         <= err_d;
      cap_vld_q     <= cap_vld_d;
      cap_id_q      <= cap_id_d;
      loc_w_q       <= loc_w_d;
      loc_b_q       <= loc_b_d;
      alive_w_q     <= alive_w_d;
      alive_b_q     <= alive_b_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      captured_q    <= captured_d;
      captured_id_q <= captured_id_d;
    end
  end

  assign location_vectors_w = loc_w_q;
  assign location_vectors_b = loc_b_q;
  assign alive_vectors_w    = alive_w_q;
  assign alive_vectors_b    = alive_b_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign err                = err_q;
  assign captured           = captured_q;
  assign captured_id        = captured_id_q;

`ifdef MOVE_COMMIT_PROMOTION_EN
  logic [NUM_PIECES-1:0] prom_w_q, prom_w_d, prom_b_q, prom_b_d;
  logic                  is_pawn;

  assign is_pawn = (pid_q >= IDX_W'(NUM_PIECES / 2));

  always_comb begin
    prom_w_d = prom_w_q;
    prom_b_d = prom_b_q;
    if (commit_ok && is_pawn) begin
      if (pl_q && (dest_q[SQ_W-1 -: 3] == 3'd7)) prom_w_d[pid_q] = 1'b1;
      if (!pl_q && (dest_q[SQ_W-1 -: 3] == 3'd0)) prom_b_d[pid_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      prom_w_q <= '0;
      prom_b_q <= '0;
    end else begin
      prom_w_q <= prom_w_d;
      prom_b_q <= prom_b_d;
    end
  end

  assign promoted_w = prom_w_q;
  assign promoted_b = prom_b_q;
`else
  assign promoted_w = '0;
  assign promoted_b = '0;
`endif

endmodule

// File: tb/tb_move_commit_unit.sv
// Self-checking bench for move_commit_unit: table of moves with a board model,
// plus reset-during-CHECK and ignored-start sequences.
module tb_move_commit_unit;

  logic        clk = 1'b0;
  logic        RST;
  logic        start;
  logic        pl;
  logic [3:0]  piece_id;
  logic [5:0]  dest_sq;
  logic [95:0] location_vectors_w, location_vectors_b;
  logic [15:0] alive_vectors_w, alive_vectors_b;
  logic        busy, done;
  logic [1:0]  err;
  logic        captured;
  logic [3:0]  captured_id;
  logic [15:0] promoted_w, promoted_b;

  move_commit_unit dut (
    .clk                (clk),
    .RST                (RST),
    .start              (start),
    .pl                 (pl),
    .piece_id           (piece_id),
    .dest_sq            (dest_sq),
    .location_vectors_w (location_vectors_w),
    .location_vectors_b (location_vectors_b),
    .alive_vectors_w    (alive_vectors_w),
    .alive_vectors_b    (alive_vectors_b),
    .busy               (busy),
    .done               (done),
    .err                (err),
    .captured           (captured),
    .captured_id        (captured_id),
    .promoted_w         (promoted_w),
    .promoted_b         (promoted_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       p;
    logic [3:0] id;
    logic [5:0] dest;
    logic [1:0] err;
    logic       cap;
    logic [3:0] cap_id;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  logic [6:0]  exp_q[$];
  logic [5:0]  m_loc_w[16];
  logic [5:0]  m_loc_b[16];
  logic [15:0] m_alive_w, m_alive_b, m_prom_w, m_prom_b;
  vec_t        tbl[13];

  // Piece files by id: K,Q,R1,R2,B1,N1,N2,B2, then pawns P8..P1.
  function automatic logic [5:0] home(input int id, input logic white);
    int files[8];
    int f;
    int r;
    files = '{4, 3, 0, 7, 2, 1, 6, 5};
    if (id < 8) begin
      f = files[id];
      r = white ? 0 : 7;
    end else begin
      f = 15 - id;
      r = white ? 1 : 6;
    end
    return 6'(r * 8 + f);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 16; k++) begin
      m_loc_w[k] = home(k, 1'b1);
      m_loc_b[k] = home(k, 1'b0);
    end
    m_alive_w = 16'hFFFF;
    m_alive_b = 16'hFFFF;
    m_prom_w  = 16'h0;
    m_prom_b  = 16'h0;
  endtask

  function automatic logic [95:0] pack_w();
    logic [95:0] v;
    for (int k = 0; k < 16; k++) v[k*6 +: 6] = m_loc_w[k];
    return v;
  endfunction

  function automatic logic [95:0] pack_b();
    logic [95:0] v;
    for (int k = 0; k < 16; k++) v[k*6 +: 6] = m_loc_b[k];
    return v;
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_board(input string tag);
    chk({tag, "_loc_w"}, location_vectors_w, pack_w());
    chk({tag, "_loc_b"}, location_vectors_b, pack_b());
    chk({tag, "_alive_w"}, 96'(alive_vectors_w), 96'(m_alive_w));
    chk({tag, "_alive_b"}, 96'(alive_vectors_b), 96'(m_alive_b));
    chk({tag, "_prom_w"}, 96'(promoted_w), 96'(m_prom_w));
    chk({tag, "_prom_b"}, 96'(promoted_b), 96'(m_prom_b));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_move(input vec_t v, input int extra_at, input string tag);
    logic [6:0] e;
    int         dones;
    int         done_cyc;
    logic       busy_ok;
    start    = 1'b1;
    pl       = v.p;
    piece_id = v.id;
    dest_sq  = v.dest;
    exp_q.push_back({v.err, v.cap, v.cap_id});
    step();
    start    = 1'b0;
    dones    = 0;
    done_cyc = -1;
    busy_ok  = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      if (busy !== (c <= 18)) busy_ok = 1'b0;
      if (done === 1'b1) begin
        dones++;
        if (dones == 1) begin
          done_cyc = c;
          if (exp_q.size() == 0) begin
            chk({tag, "_sb_underflow"}, 96'(1), 96'(0));
          end else begin
            e = exp_q.pop_front();
            chk({tag, "_err"}, 96'(err), 96'(e[6:5]));
            chk({tag, "_captured"}, 96'(captured), 96'(e[4]));
            if (e[4]) chk({tag, "_captured_id"}, 96'(captured_id), 96'(e[3:0]));
          end
        end
      end
      if (c == extra_at) begin
        start    = 1'b1;
        pl       = 1'($urandom_range(0, 1));
        piece_id = 4'($urandom_range(0, 15));
        dest_sq  = 6'($urandom_range(0, 63));
      end else begin
        start = 1'b0;
      end
      step();
    end
    chk({tag, "_done_count"}, 96'(dones), 96'(1));
    chk({tag, "_latency"}, 96'(done_cyc), 96'(18));
    chk({tag, "_busy_window"}, 96'(busy_ok), 96'(1));
    if (v.err == 2'b00) begin
      if (v.p) m_loc_w[v.id] = v.dest;
      else     m_loc_b[v.id] = v.dest;
      if (v.cap) begin
        if (v.p) m_alive_b[v.cap_id] = 1'b0;
        else     m_alive_w[v.cap_id] = 1'b0;
      end
`ifdef MOVE_COMMIT_PROMOTION_EN
      if (v.id >= 8 && v.p && v.dest[5:3] == 3'd7) m_prom_w[v.id] = 1'b1;
      if (v.id >= 8 && !v.p && v.dest[5:3] == 3'd0) m_prom_b[v.id] = 1'b1;
`endif
    end
    check_board(tag);
  endtask

  initial begin
    int dones;
    RST      = 1'b0;
    start    = 1'b0;
    pl       = 1'b0;
    piece_id = 4'd0;
    dest_sq  = 6'd0;

    //             p     id     dest   err    cap   cap_id
    tbl[0]  = '{1'b1, 4'd11, 6'd28, 2'b00, 1'b0, 4'd0};   // white P5 quiet
    tbl[1]  = '{1'b1, 4'd5,  6'd11, 2'b10, 1'b0, 4'd0};   // N1 onto own pawn
    tbl[2]  = '{1'b1, 4'd5,  6'd1,  2'b11, 1'b0, 4'd0};   // N1 null move
    tbl[3]  = '{1'b1, 4'd11, 6'd51, 2'b00, 1'b1, 4'd12};  // take black P4
    tbl[4]  = '{1'b0, 4'd12, 6'd40, 2'b01, 1'b0, 4'd0};   // dead piece
    tbl[5]  = '{1'b0, 4'd0,  6'd60, 2'b11, 1'b0, 4'd0};   // black king null
    tbl[6]  = '{1'b0, 4'd12, 6'd51, 2'b01, 1'b0, 4'd0};   // dead beats null, capture suppressed
    tbl[7]  = '{1'b1, 4'd11, 6'd59, 2'b00, 1'b1, 4'd1};   // pawn to rank 7 takes queen
    tbl[8]  = '{1'b0, 4'd6,  6'd44, 2'b00, 1'b0, 4'd0};
    tbl[9]  = '{1'b1, 4'd0,  6'd8,  2'b10, 1'b0, 4'd0};   // onto own P1 (id 15)
    tbl[10] = '{1'b0, 4'd0,  6'd28, 2'b00, 1'b0, 4'd0};
    tbl[11] = '{1'b1, 4'd4,  6'd28, 2'b00, 1'b1, 4'd0};   // king capture
    tbl[12] = '{1'b1, 4'd11, 6'd28, 2'b10, 1'b0, 4'd0};

    model_reset();
    step();
    step();
    check_board("reset");
    chk("reset_busy", 96'(busy), 96'(0));
    chk("reset_done", 96'(done), 96'(0));
    chk("reset_err", 96'(err), 96'(0));
    chk("reset_captured", 96'(captured), 96'(0));
    chk("reset_captured_id", 96'(captured_id), 96'(0));
    RST = 1'b1;
    step();

    for (int i = 0; i < 13; i++) begin
      run_move(tbl[i], (i % 2 == 1) ? int'($urandom_range(2, 15)) : 0, $sformatf("mv%0d", i));
      repeat ($urandom_range(0, 3)) step();
    end
    chk("sb_empty", 96'(exp_q.size()), 96'(0));

    // Reset in the middle of CHECK discards the move.
    start    = 1'b1;
    pl       = 1'b1;
    piece_id = 4'd4;
    dest_sq  = 6'd3;
    step();
    start = 1'b0;
    repeat (5) step();
    RST = 1'b0;
    #1;
    model_reset();
    check_board("midreset");
    chk("midreset_busy", 96'(busy), 96'(0));
    chk("midreset_done", 96'(done), 96'(0));
    chk("midreset_err", 96'(err), 96'(0));
    step();
    RST = 1'b1;
    dones = 0;
    for (int c = 0; c < 25; c++) begin
      step();
      if (done === 1'b1) dones++;
    end
    chk("midreset_no_done", 96'(dones), 96'(0));
    check_board("midreset_hold");

    run_move(tbl[0], 7, "post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
